// File: rtl/bus_grant_arbiter_if.sv
// Request/grant bundle between bus sources and the round-robin arbiter.
interface bus_grant_arbiter_if #(
  parameter int N = 32
);
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         busy;
  logic         timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter: registered grant that is always all-zero or one-hot,
// held until done, request drop, or MAX_HOLD expiry, with one turnaround cycle.
module bus_grant_arbiter #(
  parameter int N        = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                clr,
  bus_grant_arbiter_if.slave  bus
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    grant_q;
  logic            busy_q;
  logic            timeout_q;

  logic [PW-1:0]   winner_s;
  logic            found_s;
  logic            rel_norm_s;
  logic            expire_s;

  // First set request at or above last+1, wrapping modulo N; MSB flags a hit.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] last);
    logic          found;
    logic [PW-1:0] win;
    logic [PW-1:0] idx_v;
    found = 1'b0;
    win   = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_v = PW'((int'(last) + 1 + i) % N);
      if (r[idx_v] && !found) begin
        found = 1'b1;
        win   = idx_v;
      end else begin
        win   = win;
      end
    end
    return {found, win};
  endfunction

  // Winner search and release conditions for the current owner.
  always_comb begin
    {found_s, winner_s} = rr_pick(bus.req, last_q);
    rel_norm_s          = bus.done | ~bus.req[last_q];
    expire_s            = (cnt_q == CW'(MAX_HOLD - 1));
  end

  // Arbiter FSM with registered grant, busy and timeout.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      last_q    <= PW'(N - 1);
      cnt_q     <= {CW{1'b0}};
      grant_q   <= {N{1'b0}};
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_s) begin
            grant_q <= {{(N-1){1'b0}}, 1'b1} << winner_s;
            busy_q  <= 1'b1;
            last_q  <= winner_s;
            cnt_q   <= {CW{1'b0}};
            state_q <= GRANT;
          end else begin
            grant_q <= {N{1'b0}};
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (rel_norm_s || expire_s) begin
            grant_q   <= {N{1'b0}};
            busy_q    <= 1'b0;
            // Expiry only reports a timeout when it is the sole reason to release.
            timeout_q <= ~rel_norm_s;
            state_q   <= GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          grant_q <= {N{1'b0}};
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= {N{1'b0}};
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
endmodule
